// File: rtl/tmds_encoder_multi_if.sv
// Lane bundle between the packetiser, the encoder and the per-lane serialisers.
// Every vector packs lane i at the low-order end: lane 0 occupies the lowest bits.
interface tmds_encoder_multi_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
);
    logic [1:0]              mode_in;
    logic [8*NUM_CH-1:0]     data_in;
    logic [2*NUM_CH-1:0]     ctrl_in;
    logic [4*NUM_CH-1:0]     terc4_in;
    logic [10*NUM_CH-1:0]    tmds_out;
    logic [CNT_W*NUM_CH-1:0] disp_out;

    modport master (
        output mode_in, data_in, ctrl_in, terc4_in,
        input  tmds_out, disp_out
    );

    modport slave (
        input  mode_in, data_in, ctrl_in, terc4_in,
        output tmds_out, disp_out
    );
endinterface

// File: rtl/tmds_encoder_multi.sv
// N-lane TMDS encoder: video (8b/10b with DC balance), control, TERC4 and guard-band symbols.
// Two register stages: transition minimisation, then symbol selection and disparity tracking.
module tmds_encoder_multi #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    tmds_encoder_multi_if.slave bus
);
    localparam int W = CNT_W + 2;
    localparam logic signed [W-1:0] ZERO  = '0;
    localparam logic signed [W-1:0] TWO   = W'(2);
    localparam logic signed [W-1:0] FOUR  = W'(4);
    localparam logic signed [W-1:0] EIGHT = W'(8);
    localparam logic [9:0] GUARD_EVEN = 10'b1011001100;
    localparam logic [9:0] GUARD_ODD  = 10'b0100110011;

    typedef enum logic [1:0] {
        MODE_CTRL  = 2'b00,
        MODE_VIDEO = 2'b01,
        MODE_TERC4 = 2'b10,
        MODE_GUARD = 2'b11
    } mode_t;

    function automatic logic [3:0] popcount8(input logic [7:0] x);
        logic [3:0] s;
        s = '0;
        for (int j = 0; j < 8; j++) s = s + {3'b000, x[j]};
        return s;
    endfunction

    function automatic logic [8:0] min_trans(input logic [7:0] d);
        logic [3:0] n;
        logic       use_xnor;
        logic [8:0] q;
        n        = popcount8(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int j = 1; j < 8; j++)
            q[j] = use_xnor ? ~(q[j-1] ^ d[j]) : (q[j-1] ^ d[j]);
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

    function automatic logic [9:0] terc4_code(input logic [3:0] t);
        logic [9:0] s;
        case (t)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction

    // Returns {symbol, updated counter}; arithmetic is done two bits wider than the counter.
    function automatic logic [9+CNT_W:0] video_encode(input logic [8:0] qm,
                                                      input logic [3:0] n1,
                                                      input logic [CNT_W-1:0] cnt);
        logic signed [W-1:0] c, p, m, r;
        logic [9:0] s;
        c = W'($signed(cnt));
        p = W'({1'b0, n1});
        m = EIGHT - p;
        if ((c == ZERO) || (p == FOUR)) begin
            s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            r = qm[8] ? (c + p - m) : (c + m - p);
        end else if (((c > ZERO) && (p > m)) || ((c < ZERO) && (m > p))) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            r = c + (qm[8] ? TWO : ZERO) + m - p;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            r = c + p - m - (qm[8] ? ZERO : TWO);
        end
        return {s, r[CNT_W-1:0]};
    endfunction

    logic [NUM_CH-1:0][8:0]       qm_d, qm_q;
    logic [NUM_CH-1:0][3:0]       n1_d, n1_q;
    logic [2*NUM_CH-1:0]          ctrl_q;
    logic [4*NUM_CH-1:0]          terc4_q;
    mode_t                        mode_q;
    logic                         valid_q;
    logic [NUM_CH-1:0][9:0]       sym_d, sym_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        qm_d = '0;
        n1_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            qm_d[i] = min_trans(bus.data_in[8*i +: 8]);
            n1_d[i] = popcount8(qm_d[i][7:0]);
        end
    end

    // valid_q keeps the reset-cleared stage-1 contents from being emitted as control symbols.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= 1'b0;
            mode_q  <= MODE_CTRL;
            qm_q    <= '0;
            n1_q    <= '0;
            ctrl_q  <= '0;
            terc4_q <= '0;
        end else begin
            valid_q <= 1'b1;
            mode_q  <= mode_t'(bus.mode_in);
            qm_q    <= qm_d;
            n1_q    <= n1_d;
            ctrl_q  <= bus.ctrl_in;
            terc4_q <= bus.terc4_in;
        end
    end

    always_comb begin
        sym_d = '0;
        cnt_d = '0;
        if (valid_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (mode_q)
                    MODE_VIDEO: {sym_d[i], cnt_d[i]} = video_encode(qm_q[i], n1_q[i], cnt_q[i]);
                    MODE_CTRL:  sym_d[i] = ctrl_code(ctrl_q[2*i +: 2]);
                    MODE_TERC4: sym_d[i] = terc4_code(terc4_q[4*i +: 4]);
                    MODE_GUARD: sym_d[i] = ((i % 2) == 0) ? GUARD_EVEN : GUARD_ODD;
                    default:    sym_d[i] = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sym_q <= '0;
            cnt_q <= '0;
        end else begin
            sym_q <= sym_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.tmds_out = sym_q;
    assign bus.disp_out = cnt_q;
endmodule
